// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment patterns are active-low, segment a on bit 6 through g on bit 0.
package ssd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_e;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b1100000;
   localparam logic [6:0] SEG_C     = 7'b0110001;
   localparam logic [6:0] SEG_D     = 7'b1000010;
   localparam logic [6:0] SEG_E     = 7'b0110000;
   localparam logic [6:0] SEG_F     = 7'b0111000;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Width needed to count 0..n-1, never less than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module ssd_hex_decoder
   import ssd_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Table lookup over all sixteen nibble values.
   always_comb begin
      seg = SEG_BLANK;
      case (nibble)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed common-anode seven-segment scanner for 1..8 digits.
// Each digit slot is DWELL cycles: BLANK_CYCLES of dead time, then SHOW.
// Shadow registers reload only at frame boundaries so a frame never tears.
// Optional macro SSD_LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module ssd_scan_driver
   import ssd_pkg::*;
#(
   parameter int DIGITS       = 4,
   parameter int CLK_HZ       = 100_000_000,
   parameter int SCAN_HZ      = 1_000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [4*DIGITS-1:0]   digit_value,
   input  logic [DIGITS-1:0]     digit_dp,
   input  logic [DIGITS-1:0]     digit_on,
   input  logic                  load,
   output logic [6:0]            ssdCathode,
   output logic                  ssdDp,
   output logic [DIGITS-1:0]     ssdAnode,
   output logic                  frame_done
);

   localparam int DWELL = CLK_HZ / SCAN_HZ;
   localparam int CNT_W = cnt_width(DWELL);
   localparam int IDX_W = cnt_width(DIGITS);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] SLOT_END  = CNT_W'(DWELL - 1);

   if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $error("ssd_scan_driver: DIGITS must be 1..8");
   end
   if (!(DWELL > BLANK_CYCLES && BLANK_CYCLES >= 1)) begin : g_bad_timing
      $error("ssd_scan_driver: need DWELL > BLANK_CYCLES >= 1");
   end

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  pend_q, pend_d;
   logic [4*DIGITS-1:0]   sh_val_q, sh_val_d;
   logic [DIGITS-1:0]     sh_dp_q, sh_dp_d;
   logic [DIGITS-1:0]     sh_on_q, sh_on_d;
   logic [DIGITS-1:0]     anode_q, anode_d;
   logic [6:0]            cath_q, cath_d;
   logic                  dp_q, dp_d;
   logic                  fd_q, fd_d;
   logic                  boundary;
   logic [DIGITS-1:0]     supp;
   logic [DIGITS-1:0]     sel_onehot;
   logic [3:0]            sel_nib;
   logic                  sel_dp;
   logic                  sel_on;
   logic [6:0]            sel_seg;

   // Slot sequencing: dead time, lit time, digit advance and frame wrap.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      fd_d     = 1'b0;
      boundary = 1'b0;
      if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d  = BLANK;
               cnt_d    = '0;
               idx_d    = '0;
               boundary = 1'b1;
            end
            BLANK: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == BLANK_END) state_d = SHOW;
            end
            SHOW: begin
               if (cnt_q == SLOT_END) begin
                  state_d = BLANK;
                  cnt_d   = '0;
                  if (idx_q == LAST_IDX) begin
                     idx_d    = '0;
                     fd_d     = 1'b1;
                     boundary = 1'b1;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               idx_d   = '0;
            end
         endcase
      end
   end

   // Pending-load flag and shadow capture at frame boundaries.
   always_comb begin
      pend_d   = pend_q | load;
      sh_val_d = sh_val_q;
      sh_dp_d  = sh_dp_q;
      sh_on_d  = sh_on_q;
      if (boundary && (pend_q || load)) begin
         pend_d   = 1'b0;
         sh_val_d = digit_value;
         sh_dp_d  = digit_dp;
         sh_on_d  = digit_on;
      end
   end

`ifdef SSD_LEADING_ZERO_BLANK_EN
   // Leading-zero mask: blank zero digits from the top until a nonzero nibble or set dp.
   always_comb begin
      logic lead;
      supp = '0;
      lead = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (lead && (sh_val_q[4*i +: 4] == 4'h0) && !sh_dp_q[i]) supp[i] = 1'b1;
         else lead = 1'b0;
      end
   end
`else
   assign supp = '0;
`endif

   // Select the shadow data for the digit that will be active after this edge.
   always_comb begin
      sel_onehot = '0;
      sel_nib    = 4'h0;
      sel_dp     = 1'b0;
      sel_on     = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_d == IDX_W'(i)) begin
            sel_onehot[i] = 1'b1;
            sel_nib       = sh_val_q[4*i +: 4];
            sel_dp        = sh_dp_q[i];
            sel_on        = sh_on_q[i] & ~supp[i];
         end
      end
   end

   ssd_hex_decoder u_dec (
      .nibble (sel_nib),
      .seg    (sel_seg)
   );

   // Output pins follow the next state so they change on the same edge as the FSM.
   always_comb begin
      anode_d = '1;
      cath_d  = SEG_BLANK;
      dp_d    = 1'b1;
      if (state_d == SHOW && sel_on) begin
         anode_d = ~sel_onehot;
         cath_d  = sel_seg;
         dp_d    = ~sel_dp;
      end
   end

   // State, counters, shadows and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         pend_q   <= 1'b0;
         sh_val_q <= '0;
         sh_dp_q  <= '0;
         sh_on_q  <= '0;
         anode_q  <= '1;
         cath_q   <= SEG_BLANK;
         dp_q     <= 1'b1;
         fd_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         pend_q   <= pend_d;
         sh_val_q <= sh_val_d;
         sh_dp_q  <= sh_dp_d;
         sh_on_q  <= sh_on_d;
         anode_q  <= anode_d;
         cath_q   <= cath_d;
         dp_q     <= dp_d;
         fd_q     <= fd_d;
      end
   end

   assign ssdAnode   = anode_q;
   assign ssdCathode = cath_q;
   assign ssdDp      = dp_q;
   assign frame_done = fd_q;

endmodule
